cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 8-bit CPU datapath (register file, ALU, data memory, instruction-decode ROM).
- Owns the program counter and instruction register, and fetches 16-bit instructions over a valid-handshake instruction-memory port.
- Presents the instruction to the datapath and gates the decode-ROM control flags into single-cycle write/read strobes.
- Detects HALT and stops.

Parameters:
- PC_WIDTH, 8, width of program counter / instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  start request; sampled only in IDLE.
- imem_addr  output  PC_WIDTH  instruction fetch address (= pc).
- imem_req  output  1  fetch request; high throughout FETCH.
- imem_valid  input  1  imem_data valid this cycle; honoured only in FETCH.
- imem_data  input  16  fetched instruction.
- inst  output  16  instruction register to datapath (opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0], imm [7:0]).
- ctrl_flags  input  3  from decode ROM for inst[15:12]: [2]=mem_we, [1]=mem_re, [0]=ldi.
- reg_we  output  1  register-file write strobe.
- mem_we  output  1  data-memory write strobe.
- mem_re  output  1  data-memory read-select to writeback mux.
- busy  output  1  high in FETCH or EXEC.
- halted  output  1  high in HALT.
- retired  output  16  count of completed instructions.

Behaviour:
- Reset (rst=1 at posedge), takes priority over all else:
  - state=IDLE, pc=RESET_PC, inst=16'h0000, retired=0.
  - All strobes, imem_req, busy and halted are 0.
  - Any fetch in flight is abandoned; an imem_valid arriving afterwards is ignored.
- States: IDLE, FETCH, EXEC, HALT. State is encoded; outputs are decoded from state (Moore) except the strobes, which also depend on ctrl_flags.
- IDLE:
  - run=1 -> FETCH.
  - run=0 -> stay. run is ignored in every other state.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_valid=1: inst <= imem_data, -> EXEC.
  - imem_valid=0: stay; wait is unbounded. inst holds its previous value while waiting.
- EXEC (exactly one cycle):
  - Strobe values:
    - mem_we = ctrl_flags[2]
    - mem_re = ctrl_flags[1]
    - reg_we = ~ctrl_flags[2]
  - Writes commit at the posedge ending EXEC.
  - inst[15:12]=4'hC (HALT): all strobes forced to 0, retired+1, pc unchanged, -> HALT.
  - Otherwise: pc <= pc+1, wrapping modulo 2^PC_WIDTH (max -> 0); retired <= retired+1, wrapping; -> FETCH.
- Outside EXEC, reg_we, mem_we and mem_re are 0.
- HALT: all strobes 0, imem_req=0, halted=1. Exit only via rst.
- Throughput: 2 cycles per instruction when imem_valid is returned in the first FETCH cycle; in general, 1 + fetch-wait cycles + 1.
- First imem_req is asserted in the cycle after run is sampled high in IDLE.

Optional Feature:
- Macro CPU_SEQUENCER_JUMP_EN.
- Defined:
  - Opcode 4'hB is JMP.
  - In EXEC, pc <= inst[7:0] zero-extended or truncated to PC_WIDTH (not pc+1).
  - All strobes forced to 0; retired increments; -> FETCH.
- Not defined:
  - Opcode 4'hB receives no special handling: strobes follow ctrl_flags as for any other opcode, and pc increments.
- HALT handling is identical in both builds.

Test Plan:
1. Reset with run=0 for 3 cycles -> imem_req=0, pc=0, inst=0, retired=0, busy=0. Then run=1 for one cycle -> imem_req=1, imem_addr=0 the next cycle.
2. Zero-wait memory returning F10A, F202, 0112, C000 at addresses 0..3:
   - reg_we pulses once per instruction, each pulse 1 cycle, 2 cycles apart.
   - halted=1 after the 8th cycle of busy.
   - retired=4, pc=3.
   - With the real datapath attached, x1=12.
3. Memory pattern:
   - imem_valid delayed 3 cycles on address 1 (D012) -> inst holds F104 while waiting.
   - For D012: mem_we=1 and reg_we=0 for exactly 1 cycle in EXEC.
   - For E310: mem_re=1 and reg_we=1.
4. PC_WIDTH=2, program of four F0xx instructions then C000 -> imem_addr sequence 0,1,2,3,0 (wrap); halts at address 0; retired=5.
5. rst asserted in the cycle imem_valid=1 -> IDLE next cycle, inst=0, no strobes. imem_valid pulsed in IDLE is ignored.
6. With CPU_SEQUENCER_JUMP_EN, program B003 at address 0 -> next imem_addr=3, no strobes in that EXEC. Without the macro -> next imem_addr=1.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch and datapath-control bundle between the sequencer and the
// 8-bit CPU datapath (instruction memory, decode ROM, register file, data memory).
interface cpu_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_req;
    logic                imem_valid;
    logic [15:0]         imem_data;
    logic [15:0]         inst;
    logic [2:0]          ctrl_flags;
    logic                reg_we;
    logic                mem_we;
    logic                mem_re;

    modport master (
        output imem_addr, imem_req, inst, reg_we, mem_we, mem_re,
        input  imem_valid, imem_data, ctrl_flags
    );

    modport slave (
        input  imem_addr, imem_req, inst, reg_we, mem_we, mem_re,
        output imem_valid, imem_data, ctrl_flags
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns pc and instruction register, gates decode
// flags into one-cycle strobes, stops on HALT. Optional JMP opcode via CPU_SEQUENCER_JUMP_EN.
module cpu_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    cpu_sequencer_if.master      bus,
    output logic                 busy,
    output logic                 halted,
    output logic [15:0]          retired
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hB;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         inst_q, inst_d;
    logic [15:0]         retired_q, retired_d;
    logic                reg_we_s;
    logic                mem_we_s;
    logic                mem_re_s;
    logic                is_halt_s;
    logic                is_jmp_s;
    logic                unused_s;

    assign is_halt_s = (inst_q[15:12] == OP_HALT);
    assign is_jmp_s  = (inst_q[15:12] == OP_JMP);
    // ldi selects the writeback source inside the datapath; the sequencer never needs it
    assign unused_s  = bus.ctrl_flags[0] ^ is_jmp_s;

    // State, program counter, instruction register and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_WIDTH'(RESET_PC);
            inst_q    <= 16'h0000;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        reg_we_s  = 1'b0;
        mem_we_s  = 1'b0;
        mem_re_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.imem_valid) begin
                    inst_d  = bus.imem_data;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                retired_d = retired_q + 16'd1;
                if (is_halt_s) begin
                    state_d = ST_HALT;
                end
`ifdef CPU_SEQUENCER_JUMP_EN
                else if (is_jmp_s) begin
                    // Target is the 8-bit immediate, resized to the pc width
                    pc_d    = PC_WIDTH'(inst_q[7:0]);
                    state_d = ST_FETCH;
                end
`endif
                else begin
                    mem_we_s = bus.ctrl_flags[2];
                    mem_re_s = bus.ctrl_flags[1];
                    reg_we_s = ~bus.ctrl_flags[2];
                    pc_d     = pc_q + PC_WIDTH'(1'b1);
                    state_d  = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.imem_req  = (state_q == ST_FETCH);
    assign bus.inst      = inst_q;
    assign bus.reg_we    = reg_we_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_re    = mem_re_s;
    assign busy          = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted        = (state_q == ST_HALT);
    assign retired       = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: an 8-bit-pc instance for most scenarios and a
// 2-bit-pc instance for pc wrap-around.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        run2;
    logic        busy, halted, busy2, halted2;
    logic [15:0] retired, retired2;
    logic [15:0] rom1 [0:255];
    logic [15:0] prog2 [0:4];
    int          n_checks;
    int          n_pass;

    cpu_sequencer_if #(.PC_WIDTH(8)) bus1 ();
    cpu_sequencer_if #(.PC_WIDTH(2)) bus2 ();

    cpu_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) u_dut (
        .clk(clk), .rst(rst), .run(run), .bus(bus1),
        .busy(busy), .halted(halted), .retired(retired)
    );

    cpu_sequencer #(.PC_WIDTH(2), .RESET_PC(0)) u_dut2 (
        .clk(clk), .rst(rst), .run(run2), .bus(bus2),
        .busy(busy2), .halted(halted2), .retired(retired2)
    );

    // Decode-ROM model: D=store, E=load, F=ldi; B and C carry flags that must be masked
    function automatic logic [2:0] dec(input logic [3:0] op);
        case (op)
            4'hD:    dec = 3'b100;
            4'hE:    dec = 3'b010;
            4'hF:    dec = 3'b001;
            4'hB:    dec = 3'b010;
            4'hC:    dec = 3'b010;
            default: dec = 3'b000;
        endcase
    endfunction

    assign bus1.imem_data  = rom1[bus1.imem_addr];
    assign bus1.ctrl_flags = dec(bus1.inst[15:12]);
    assign bus2.ctrl_flags = dec(bus2.inst[15:12]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_strobes(input string tag, input logic r, input logic w, input logic m);
        chk({tag, ".reg_we"}, {31'd0, bus1.reg_we}, {31'd0, r});
        chk({tag, ".mem_we"}, {31'd0, bus1.mem_we}, {31'd0, w});
        chk({tag, ".mem_re"}, {31'd0, bus1.mem_re}, {31'd0, m});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_inst [0:3];
        logic        exp_rwe  [0:3];
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; run = 1'b0; run2 = 1'b0;
        bus1.imem_valid = 1'b0;
        bus2.imem_valid = 1'b1;
        bus2.imem_data  = 16'h0000;
        for (int i = 0; i < 256; i++) rom1[i] = 16'h0000;

        // Test 1: reset state, then first fetch request
        tick(); tick(); tick();
        chk("rst.req",     {31'd0, bus1.imem_req}, 32'd0);
        chk("rst.addr",    {24'd0, bus1.imem_addr}, 32'd0);
        chk("rst.inst",    {16'd0, bus1.inst}, 32'd0);
        chk("rst.retired", {16'd0, retired}, 32'd0);
        chk("rst.busy",    {31'd0, busy}, 32'd0);
        chk("rst.halted",  {31'd0, halted}, 32'd0);
        chk_strobes("rst", 1'b0, 1'b0, 1'b0);
        rom1[0] = 16'hF10A; rom1[1] = 16'hF202; rom1[2] = 16'h0112; rom1[3] = 16'hC000;
        rst = 1'b0;
        tick();
        chk("idle.req", {31'd0, bus1.imem_req}, 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("t1.req",  {31'd0, bus1.imem_req}, 32'd1);
        chk("t1.addr", {24'd0, bus1.imem_addr}, 32'd0);

        // Test 2: zero-wait program, 2 cycles per instruction
        bus1.imem_valid = 1'b1;
        exp_inst[0] = 16'hF10A; exp_inst[1] = 16'hF202;
        exp_inst[2] = 16'h0112; exp_inst[3] = 16'hC000;
        exp_rwe[0] = 1'b1; exp_rwe[1] = 1'b1; exp_rwe[2] = 1'b1; exp_rwe[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2.fetch_addr", {24'd0, bus1.imem_addr}, i);
            chk("t2.fetch_busy", {31'd0, busy}, 32'd1);
            chk_strobes("t2.fetch", 1'b0, 1'b0, 1'b0);
            tick();
            chk("t2.exec_inst", {16'd0, bus1.inst}, {16'd0, exp_inst[i]});
            chk("t2.exec_req",  {31'd0, bus1.imem_req}, 32'd0);
            chk_strobes("t2.exec", exp_rwe[i], 1'b0, 1'b0);
            tick();
        end
        chk("t2.halted",  {31'd0, halted}, 32'd1);
        chk("t2.busy",    {31'd0, busy}, 32'd0);
        chk("t2.retired", {16'd0, retired}, 32'd4);
        chk("t2.pc",      {24'd0, bus1.imem_addr}, 32'd3);
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        chk("t2.stay_halted", {31'd0, halted}, 32'd1);
        chk("t2.stay_retired", {16'd0, retired}, 32'd4);
        chk_strobes("t2.halt", 1'b0, 1'b0, 1'b0);

        // Test 3: fetch wait on address 1, store and load strobes
        rom1[0] = 16'hF104; rom1[1] = 16'hD012; rom1[2] = 16'hE310; rom1[3] = 16'hC000;
        do_reset();
        chk("t3.rst_inst", {16'd0, bus1.inst}, 32'd0);
        chk("t3.rst_halted", {31'd0, halted}, 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("t3.exec0_inst", {16'd0, bus1.inst}, 32'hF104);
        bus1.imem_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3.wait_req",  {31'd0, bus1.imem_req}, 32'd1);
            chk("t3.wait_addr", {24'd0, bus1.imem_addr}, 32'd1);
            chk("t3.wait_inst", {16'd0, bus1.inst}, 32'hF104);
            chk_strobes("t3.wait", 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("t3.still_wait", {31'd0, bus1.imem_req}, 32'd1);
        bus1.imem_valid = 1'b1;
        tick();
        chk("t3.st_inst", {16'd0, bus1.inst}, 32'hD012);
        chk_strobes("t3.store", 1'b0, 1'b1, 1'b0);
        tick();
        chk_strobes("t3.after_store", 1'b0, 1'b0, 1'b0);
        tick();
        chk("t3.ld_inst", {16'd0, bus1.inst}, 32'hE310);
        chk_strobes("t3.load", 1'b1, 1'b0, 1'b1);
        tick(); tick(); tick();
        chk("t3.halted",  {31'd0, halted}, 32'd1);
        chk("t3.retired", {16'd0, retired}, 32'd4);

        // Test 5: reset wins over imem_valid; valid ignored in IDLE
        do_reset();
        run = 1'b1;
        bus1.imem_valid = 1'b0;
        tick();
        run = 1'b0;
        tick();
        chk("t5.fetching", {31'd0, bus1.imem_req}, 32'd1);
        bus1.imem_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5.inst", {16'd0, bus1.inst}, 32'd0);
        chk("t5.busy", {31'd0, busy}, 32'd0);
        chk("t5.req",  {31'd0, bus1.imem_req}, 32'd0);
        chk_strobes("t5.rst", 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("t5.idle_inst", {16'd0, bus1.inst}, 32'd0);
        chk("t5.idle_busy", {31'd0, busy}, 32'd0);
        chk("t5.idle_ret",  {16'd0, retired}, 32'd0);
        chk_strobes("t5.idle", 1'b0, 1'b0, 1'b0);

        // Test 6: opcode B, jump or plain increment depending on build
        rom1[0] = 16'hB003; rom1[1] = 16'hC000; rom1[3] = 16'hC000;
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("t6.inst", {16'd0, bus1.inst}, 32'hB003);
`ifdef CPU_SEQUENCER_JUMP_EN
        chk_strobes("t6.jmp", 1'b0, 1'b0, 1'b0);
        tick();
        chk("t6.next_addr", {24'd0, bus1.imem_addr}, 32'd3);
`else
        chk_strobes("t6.plainB", 1'b1, 1'b0, 1'b1);
        tick();
        chk("t6.next_addr", {24'd0, bus1.imem_addr}, 32'd1);
`endif
        tick(); tick();
        chk("t6.halted",  {31'd0, halted}, 32'd1);
        chk("t6.retired", {16'd0, retired}, 32'd2);

        // Test 4: 2-bit pc wraps 3 -> 0 and halts there
        prog2[0] = 16'hF001; prog2[1] = 16'hF002; prog2[2] = 16'hF003;
        prog2[3] = 16'hF004; prog2[4] = 16'hC000;
        bus1.imem_valid = 1'b0;
        do_reset();
        run2 = 1'b1;
        tick();
        run2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t4.addr", {30'd0, bus2.imem_addr}, k % 4);
            chk("t4.req",  {31'd0, bus2.imem_req}, 32'd1);
            bus2.imem_data = prog2[k];
            tick();
            chk("t4.inst", {16'd0, bus2.inst}, {16'd0, prog2[k]});
            tick();
        end
        chk("t4.halted",  {31'd0, halted2}, 32'd1);
        chk("t4.retired", {16'd0, retired2}, 32'd5);
        chk("t4.pc",      {30'd0, bus2.imem_addr}, 32'd0);
        chk("t4.dut1_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
